// File: rtl/rc_filter_pkg.sv
// rc_filter_pkg: shared definitions for the polyphase raised-cosine filter.
//   acc_width      - full-precision accumulator width for a TAPS-term dot product
//   DEFAULT_COEFS  - raised-cosine taps, rolloff 0.5, OS=4, TAPS=6, S(8,7),
//                    coefficient k at bits [k*8 +: 8], peak (127) at k=12
//   format_sample  - arithmetic right shift with optional round half-up and
//                    saturation; the caller keeps the low S_OUT bits
//   run_state_t    - output-valid priming state
package rc_filter_pkg;

  localparam int DEF_OS     = 4;
  localparam int DEF_TAPS   = 6;
  localparam int DEF_S_COEF = 8;
  localparam int FMT_W      = 64;

  typedef enum logic {
    ST_PRIME,
    ST_RUN
  } run_state_t;

  // Raised cosine sampled at t = (k-12)/4 symbols, scaled by 128 and clipped
  // to 127; listed from k=23 (MSB) down to k=0 (LSB).
  localparam logic [DEF_OS*DEF_TAPS*DEF_S_COEF-1:0] DEFAULT_COEFS =
    192'h0102_0300_F9F1_F000_224D_727F_724D_2200_F0F1_F900_0302_0100;

  function automatic int acc_width(input int s_coef, input int s_in, input int taps);
    return s_coef + s_in + $clog2(taps);
  endfunction

  // Rounding adds half an output LSB before the shift so that ties go up.
  function automatic logic signed [FMT_W-1:0] format_sample(
    input logic signed [FMT_W-1:0] acc,
    input int                      shift,
    input int                      s_out,
    input bit                      sat_en
  );
    logic signed [FMT_W-1:0] one;
    logic signed [FMT_W-1:0] v;
    logic signed [FMT_W-1:0] hi;
    logic signed [FMT_W-1:0] lo;
    one = 1;
    v   = acc;
    if (sat_en && (shift > 0)) v = v + (one <<< (shift - 1));
    v  = v >>> shift;
    hi = (one <<< (s_out - 1)) - one;
    lo = -(one <<< (s_out - 1));
    if (sat_en) begin
      if (v > hi) v = hi;
      else if (v < lo) v = lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/rc_filter_poly_if.sv
// rc_filter_poly_if: symbol-in / sample-out bus of the polyphase RC filter.
//   i_valid, i_symbol              - symbol source -> filter
//   o_ready, o_valid, o_filter,
//   o_underflow                    - filter -> source / sink
// Modports: master = symbol source and sample sink, slave = the filter.
interface rc_filter_poly_if #(
  parameter int N_CH  = 2,
  parameter int S_IN  = 2,
  parameter int S_OUT = 10
) ();

  logic                    i_valid;
  logic [N_CH*S_IN-1:0]    i_symbol;
  logic                    o_ready;
  logic                    o_valid;
  logic [N_CH*S_OUT-1:0]   o_filter;
  logic                    o_underflow;

  modport master (
    output i_valid, i_symbol,
    input  o_ready, o_valid, o_filter, o_underflow
  );

  modport slave (
    input  i_valid, i_symbol,
    output o_ready, o_valid, o_filter, o_underflow
  );

endinterface

// File: rtl/rc_filter_mac.sv
// rc_filter_mac: one channel's TAPS-deep symbol delay line and the
// TAPS-term dot product against the coefficients of a selected phase.
//   clock, i_reset - rising-edge clock, synchronous active-high reset
//   i_shift        - shift the delay line, i_sample enters x[0]
//   i_sample       - signed symbol (already zeroed on underflow)
//   i_phase        - polyphase branch, selects COEFS[t*OS + i_phase]
//   o_acc          - full-precision signed dot product (combinational)
module rc_filter_mac
  import rc_filter_pkg::*;
#(
  parameter int OS     = 4,
  parameter int TAPS   = 6,
  parameter int S_COEF = 8,
  parameter int S_IN   = 2,
  parameter int S_ACC  = acc_width(S_COEF, S_IN, TAPS),
  parameter logic [OS*TAPS*S_COEF-1:0] COEFS = DEFAULT_COEFS
) (
  input  logic                    clock,
  input  logic                    i_reset,
  input  logic                    i_shift,
  input  logic signed [S_IN-1:0]  i_sample,
  input  logic [$clog2(OS)-1:0]   i_phase,
  output logic signed [S_ACC-1:0] o_acc
);

  logic signed [S_IN-1:0] taps_q [TAPS];

  always_ff @(posedge clock) begin
    if (i_reset) begin
      for (int t = 0; t < TAPS; t++) taps_q[t] <= '0;
    end else if (i_shift) begin
      taps_q[0] <= i_sample;
      for (int t = 1; t < TAPS; t++) taps_q[t] <= taps_q[t-1];
    end
  end

  // Both factors are sign-extended to the accumulator width first, so the
  // products and the sum are exact.
  always_comb begin
    logic signed [S_COEF-1:0] coef;
    coef  = '0;
    o_acc = '0;
    for (int t = 0; t < TAPS; t++) begin
      coef  = COEFS[(t*OS + int'(i_phase))*S_COEF +: S_COEF];
      o_acc = o_acc + S_ACC'(coef) * S_ACC'(taps_q[t]);
    end
  end

endmodule

// File: rtl/rc_filter_poly.sv
// rc_filter_poly: N_CH-channel polyphase raised-cosine transmit filter.
// Accepts one symbol per channel every OS enabled cycles and emits one
// filtered sample per channel every enabled cycle.
//   clock      - rising-edge clock
//   i_reset    - synchronous active-high reset, priority over i_enable
//   i_enable   - global clock enable, low freezes all state
//   bus        - rc_filter_poly_if.slave: i_valid/i_symbol in,
//                o_ready/o_valid/o_filter/o_underflow out
// Build option: RC_FILTER_SAT_EN selects round half-up plus saturation;
// without it the output is floored and wrapped to S_OUT bits.
module rc_filter_poly
  import rc_filter_pkg::*;
#(
  parameter int OS        = 4,
  parameter int TAPS      = 6,
  parameter int S_COEF    = 8,
  parameter int S_IN      = 2,
  parameter int N_CH      = 2,
  parameter int S_OUT     = 10,
  parameter int OUT_SHIFT = 0,
  parameter logic [OS*TAPS*S_COEF-1:0] COEFS = DEFAULT_COEFS
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_enable,
  rc_filter_poly_if.slave  bus
);

  localparam int S_ACC = acc_width(S_COEF, S_IN, TAPS);
  localparam int PH_W  = $clog2(OS);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OS - 1);

`ifdef RC_FILTER_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic [PH_W-1:0]         ph;
  logic [PH_W-1:0]         ph_d;
  run_state_t              state;
  run_state_t              state_next;
  logic                    accept;
  logic signed [S_ACC-1:0] acc [N_CH];
  logic [N_CH*S_OUT-1:0]   filter_q;
  logic [N_CH*S_OUT-1:0]   filter_next;
  logic                    valid_q;
  logic                    underflow_q;

  assign accept          = i_enable && (ph == '0);
  assign bus.o_ready     = accept;
  assign bus.o_valid     = valid_q;
  assign bus.o_filter    = filter_q;
  assign bus.o_underflow = underflow_q;

  // A missing symbol at an accept slot is replaced by zero so the sample
  // rate never stalls.
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic signed [S_IN-1:0] sample;
    assign sample = bus.i_valid ? bus.i_symbol[c*S_IN +: S_IN] : '0;

    rc_filter_mac #(
      .OS     (OS),
      .TAPS   (TAPS),
      .S_COEF (S_COEF),
      .S_IN   (S_IN),
      .S_ACC  (S_ACC),
      .COEFS  (COEFS)
    ) u_mac (
      .clock    (clock),
      .i_reset  (i_reset),
      .i_shift  (accept),
      .i_sample (sample),
      .i_phase  (ph_d),
      .o_acc    (acc[c])
    );
  end

  always_ff @(posedge clock) begin
    if (i_reset) state <= ST_PRIME;
    else         state <= state_next;
  end

  // The output register holds a meaningless zero after the first enabled
  // edge, so o_valid only starts once one enabled cycle has passed.
  always_comb begin
    state_next = state;
    case (state)
      ST_PRIME: if (i_enable) state_next = ST_RUN;
      ST_RUN:   state_next = ST_RUN;
      default:  state_next = ST_PRIME;
    endcase
  end

  always_comb begin
    filter_next = '0;
    for (int c = 0; c < N_CH; c++) begin
      filter_next[c*S_OUT +: S_OUT] =
        S_OUT'(format_sample(FMT_W'(acc[c]), OUT_SHIFT, S_OUT, SAT_EN));
    end
  end

  // The output register samples the delay line as it stands before any
  // shift on the same edge, which gives the two-edge accept-to-sample delay.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      ph          <= '0;
      ph_d        <= '0;
      filter_q    <= '0;
      valid_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      valid_q     <= i_enable && (state == ST_RUN);
      underflow_q <= accept && !bus.i_valid;
      if (i_enable) begin
        ph       <= (ph == PH_LAST) ? '0 : ph + PH_W'(1);
        ph_d     <= ph;
        filter_q <= filter_next;
      end
    end
  end

endmodule

// File: doc/rc_filter_poly.md
# rc_filter_poly

Parametrised multi-channel polyphase raised-cosine transmit filter, successor to the fixed single-channel RC filter. Sits between the symbol mapper and the DAC/channel model. It takes one signed symbol per channel every OS enabled cycles and emits one filtered sample per channel every enabled cycle. Adds a ready/valid handshake, zero-stuffing on underflow, and an output window with optional round/saturate.

## Interface
- OS, 4: oversampling factor (phases per symbol), ≥2
- TAPS, 6: symbol-spaced taps per phase
- S_COEF, 8: signed coefficient width
- S_IN, 2: signed symbol width
- N_CH, 2: independent channels (I/Q default)
- S_OUT, 10: signed output width per channel
- OUT_SHIFT, 0: LSBs dropped from accumulator before output
- COEFS, rc_filter_pkg default: packed OS*TAPS*S_COEF vector, coefficient k = t*OS+p at bits [k*S_COEF +: S_COEF]
- clock  in  1  single clock, rising edge
- i_reset  in  1  synchronous, active-high
- i_enable  in  1  global clock enable; low freezes all state
- i_valid  in  1  symbol bus valid
- i_symbol  in  N_CH*S_IN  channel c at [c*S_IN +: S_IN], two's complement
- o_ready  out  1  symbol accepted this cycle if i_valid
- o_valid  out  1  o_filter holds a new sample
- o_filter  out  N_CH*S_OUT  channel c at [c*S_OUT +: S_OUT]
- o_underflow  out  1  one-cycle pulse: zero symbol stuffed

## Operation
- S_ACC = S_COEF+S_IN+clog2(TAPS); accumulator full precision, never overflows.
- Phase counter ph: 0..OS-1, advances on every enabled cycle, wraps OS-1→0.
- o_ready = i_enable & (ph==0), combinational.
- At ph==0 with i_enable: each channel's TAPS-deep delay line shifts; x[0] ← i_symbol if i_valid, else 0 with o_underflow=1 next cycle.
- i_valid outside ph==0 is ignored (no accept, no error).
- Registered phase ph_d ← ph every enabled cycle; output stage: acc_c = Σ_t COEFS[t*OS+ph_d] * x_c[t], signed.
- o_filter_c ← acc_c >> OUT_SHIFT (arithmetic), then reduced to S_OUT bits per Configuration.
- i_enable low: ph, ph_d, delay lines, o_filter hold; o_valid=0; o_underflow=0.
- Reset: ph=0, ph_d=0, delay lines 0, o_filter=0, o_valid=0, o_underflow=0. Reset has priority over i_enable; mid-symbol reset discards history and the next accept is at the first enabled cycle after reset release.

## Timing
- Accept at edge E0 (ph==0); sample for phase 0 of that symbol valid after E1; latency 2 edges.
- Steady state: o_valid high every enabled cycle after the first enabled cycle post-reset.
- Impulse response length OS*TAPS output samples.
- Simultaneous accept and output: output at E0 uses delay-line contents before the shift.

## Configuration
- RC_FILTER_SAT_EN defined: round half-up (add 2^(OUT_SHIFT-1) before shift when OUT_SHIFT>0), then saturate to [-2^(S_OUT-1), 2^(S_OUT-1)-1].
- Undefined: floor (plain arithmetic shift), keep low S_OUT bits (two's-complement wrap).

## Structure
- rc_filter_pkg: S_ACC width function, default RC coefficient vector (rolloff 0.5, OS=4, TAPS=6, S(8,7)), sat/round function.
- Sub-module rc_filter_mac: one channel's delay line plus TAPS-term dot product for a given phase, instantiated N_CH times; phase counter, handshake and output formatting in the top.

## Test plan
- Impulse: S_OUT=S_ACC, ch0 symbol +1 then zeros -> o_filter_0 sequence equals COEFS[0..23] in order; ch1 stays 0.
- Underflow: i_valid low at one ph==0 -> o_underflow pulses 1 cycle; output equals response with a 0 symbol; o_valid unchanged.
- Enable gap: drop i_enable 3 cycles mid-symbol -> o_valid low, o_filter held, sequence resumes without skip or repeat.
- Saturation: all COEFS=127, six symbols -2, OUT_SHIFT=0, S_OUT=10 -> acc=-1524; SAT_EN gives -512, without gives -500.
- Rounding: OUT_SHIFT=2, acc=+6 -> SAT_EN gives 2, without gives 1; acc=-6 -> -1 vs -2.
- Reset mid-operation: assert i_reset at ph==2 -> next cycle outputs 0, ph restarts at 0, prior symbols absent from response.
